// File: rtl/excpt_arbiter.sv
// Exception/interrupt arbiter: latches MEM-stage sync exceptions and IRQs, saves EPC/cause,
// then runs flush -> redirect. Define VECTORED_IRQ_EN for per-line IRQ vectors and causes.
module excpt_arbiter #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        NUM_IRQ   = 6,
  parameter int unsigned        FLUSH_CYC = 2,
  parameter logic [ADDR_W-1:0]  EXC_VEC   = ADDR_W'(32'h40),
  parameter logic [ADDR_W-1:0]  IRQ_VEC   = ADDR_W'(32'h50),
  parameter int unsigned        VEC_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        excptype,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               ie_we,
  input  logic               ie_wdata,
  input  logic               redir_ack,
  output logic               flush,
  output logic               excpt,
  output logic [ADDR_W-1:0]  ejpc,
  output logic [ADDR_W-1:0]  epc_o,
  output logic [4:0]         cause_o,
  output logic               ie_o,
  output logic [NUM_IRQ-1:0] pend_o,
  output logic               busy
);

`ifdef VECTORED_IRQ_EN
  localparam bit VectoredIrq = 1'b1;
`else
  localparam bit VectoredIrq = 1'b0;
`endif

  localparam logic [3:0] FlushLast = 4'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {StIdle, StFlush, StRedir} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               ie_q, ie_d;
  logic [ADDR_W-1:0]  ejpc_q, ejpc_d;
  logic [ADDR_W-1:0]  epc_q, epc_d;
  logic [4:0]         cause_q, cause_d;

  logic               is_sys, is_eret, is_ri, is_ov, any_sync;
  logic [NUM_IRQ-1:0] pend_en;
  logic [2:0]         irq_idx;
  logic               irq_elig, accept, irq_take;
  logic [NUM_IRQ-1:0] irq_onehot;
  logic [ADDR_W-1:0]  irq_target;
  logic [4:0]         irq_cause;

  // Only syscall, eret, RI and Ov are decoded; the rest of excptype is don't-care.
  logic unused_excptype;
  assign unused_excptype = ^{excptype[31:13], excptype[11], excptype[7:0]};

  assign is_sys   = excptype[8];
  assign is_eret  = excptype[9];
  assign is_ri    = excptype[10];
  assign is_ov    = excptype[12];
  assign any_sync = is_sys | is_eret | is_ri | is_ov;

  assign pend_en  = pend_q & mask_q;
  assign irq_elig = ie_q & (|pend_en) & ~any_sync;
  assign accept   = (state_q == StIdle) & (any_sync | irq_elig);
  assign irq_take = accept & ~any_sync;

  // Lowest enabled pending line wins.
  always_comb begin
    irq_idx = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_en[i]) irq_idx = 3'(i);
    end
  end

  assign irq_onehot = NUM_IRQ'(1) << irq_idx;
  assign irq_target = VectoredIrq ? IRQ_VEC + (ADDR_W'(irq_idx) << VEC_SHIFT) : IRQ_VEC;
  assign irq_cause  = VectoredIrq ? {2'b00, irq_idx} : 5'd0;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StFlush;
      StFlush: if (cnt_q == FlushLast) state_d = StRedir;
      StRedir: if (redir_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    flush = (state_q == StFlush);
    excpt = (state_q == StRedir);
    busy  = (state_q != StIdle);
  end

  // Datapath next-state
  always_comb begin
    cnt_d   = cnt_q;
    pend_d  = pend_q | irq_i;
    mask_d  = mask_we ? mask_wdata : mask_q;
    ie_d    = ie_we ? ie_wdata : ie_q;
    ejpc_d  = ejpc_q;
    epc_d   = epc_q;
    cause_d = cause_q;

    if (state_q == StFlush) cnt_d = cnt_q + 4'd1;

    if (accept) begin
      cnt_d = 4'd0;
      if (is_eret) begin
        ejpc_d = epc_q;
        ie_d   = 1'b1;
      end else begin
        epc_d = pc_i;
        ie_d  = 1'b0;
        if (is_sys) begin
          cause_d = 5'd8;
          ejpc_d  = EXC_VEC;
        end else if (is_ri) begin
          cause_d = 5'd10;
          ejpc_d  = EXC_VEC;
        end else if (is_ov) begin
          cause_d = 5'd12;
          ejpc_d  = EXC_VEC;
        end else begin
          cause_d = irq_cause;
          ejpc_d  = irq_target;
        end
      end
    end

    // A line still high this cycle re-pends on the following edge.
    if (irq_take) pend_d = (pend_q | irq_i) & ~irq_onehot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      pend_q  <= '0;
      mask_q  <= '1;
      ie_q    <= 1'b1;
      ejpc_q  <= '0;
      epc_q   <= '0;
      cause_q <= 5'd0;
    end else begin
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      ie_q    <= ie_d;
      ejpc_q  <= ejpc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  assign ejpc    = ejpc_q;
  assign epc_o   = epc_q;
  assign cause_o = cause_q;
  assign ie_o    = ie_q;
  assign pend_o  = pend_q;

endmodule
